// File: rtl/bcd_7seg_pkg.sv
// Shared types and segment encodings for the four-digit BCD scan display.
// Latency: none (types and constants only).
// Backpressure: none.
package bcd_7seg_pkg;

    typedef logic [3:0] digit_t;

    localparam int NUM_DIGITS = 4;

    // Bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD nibble to seven-segment pattern; non-decimal codes show a dash.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_7seg
    import bcd_7seg_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Four-digit multiplexed 7-seg driver with load-strobed shadow register; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: a load or scan step is visible on an/seg right after the capturing edge.
// Backpressure: none; load is accepted every cycle and never disturbs the scan.
module bcd_7seg_scan
    import bcd_7seg_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      scan_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [1:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    terminal;
    digit_t                  cur_digit;
    logic [6:0]              dec_seg;

    always_comb begin
        terminal = (presc_q == PRESC_MAX);
        presc_d  = terminal ? '0 : presc_q + PW'(1);
        idx_d    = terminal ? idx_q + 2'd1 : idx_q;
        shadow_d = load ? digits_in : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        cur_digit = shadow_q[3:0];
        case (idx_q)
            2'd1:    cur_digit = shadow_q[7:4];
            2'd2:    cur_digit = shadow_q[11:8];
            2'd3:    cur_digit = shadow_q[15:12];
            default: cur_digit = shadow_q[3:0];
        endcase
    end

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    assign an        = 4'b0001 << idx_q;
    assign scan_tick = terminal;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only if it and every more-significant nibble are zero; digit 0 always shows.
    logic blank;

    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd1:    blank = (shadow_q[15:4]  == '0);
            2'd2:    blank = (shadow_q[15:8]  == '0);
            2'd3:    blank = (shadow_q[15:12] == '0);
            default: blank = 1'b0;
        endcase
    end

    assign seg = blank ? SEG_BLANK : dec_seg;
`else
    assign seg = dec_seg;
`endif

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 SHALL have parameter: SCAN_DIV, 4, clock cycles per displayed digit (legal range >=1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: digits_in  input  16  four BCD nibbles from cascaded count_M10 stages; [3:0] least significant digit (digit 0).
REQ-005 SHALL have port: load  input  1  capture strobe: copy digits_in into the shadow register.
REQ-006 SHALL have port: an  output  4  one-hot digit enable, active-high; bit k selects digit k.
REQ-007 SHALL have port: seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-008 SHALL have port: scan_tick  output  1  one-cycle pulse on the cycle the digit index advances.

Function
REQ-009 SHALL hold a 16-bit shadow register; on an edge with load=1 and rst=0 it SHALL take digits_in; otherwise it holds.
REQ-010 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and advance digit index idx 0->1->2->3->0.
REQ-011 SHALL assert scan_tick combinationally while prescaler is at terminal count (high exactly one cycle per SCAN_DIV cycles); SCAN_DIV=1 SHALL hold scan_tick high and advance idx every cycle.
REQ-012 SHALL drive an = one-hot(idx) and seg = decode(shadow nibble idx), combinational from registers: a load at edge N is visible right after edge N.
REQ-013 SHALL decode 0..9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-014 SHALL decode nibbles A..F as dash 40 (g only).
REQ-015 load SHALL NOT disturb prescaler or idx.

Reset
REQ-016 rst=1 at an edge SHALL clear prescaler, idx and shadow to 0, overriding load at the same edge.
REQ-017 While held in or just out of reset: an=0001, seg=3F, scan_tick=0 (SCAN_DIV>1).
REQ-018 Reset mid-scan SHALL restart the full SCAN_DIV period of digit 0 from the next edge.

Configuration
REQ-019 Macro LEADING_ZERO_BLANK_EN defined: digit k (k=1..3) SHALL output seg=00 when it and all higher digits are zero; digit 0 never blanked; A..F count as non-zero.
REQ-020 Macro undefined: no blanking logic SHALL be present; zero digits decode to 3F.

Structure
REQ-021 Package bcd_7seg_pkg SHALL hold: typedef digit_t (4-bit), NUM_DIGITS=4, segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
REQ-022 Sub-module bcd_to_7seg (combinational, digit_t -> 7-bit pattern) SHALL implement REQ-013/014; blanking SHALL stay in bcd_7seg_scan.

Verification (SCAN_DIV=4 unless stated)
REQ-023 rst=1 two cycles -> an=0001, seg=3F, scan_tick=0.
REQ-024 load 16'h1234 one cycle, then idle -> an 0001/0010/0100/1000 four cycles each, seg 66/4F/5B/06, scan_tick every 4th cycle, sequence repeats.
REQ-025 load 16'h00A5 -> digit1 seg=40, digit0 seg=6D; without macro digits2/3 seg=3F.
REQ-026 with LEADING_ZERO_BLANK_EN, load 16'h0070 -> digit0 3F, digit1 07, digits2/3 00; load 16'h0000 -> digit0 3F, others 00.
REQ-027 rst asserted while idx=2, same edge load=1 with 16'h9999 -> next cycle an=0001, seg=3F, 4 cycles before idx=1.
REQ-028 count_M10 output on digits_in[3:0], load=1 every cycle, SCAN_DIV=1 -> digit0 seg tracks 3F,06,...,6F then 3F on count_M10 reset.
